// File: rtl/cnn_accel_pkg.sv
// Shared defaults, lane index type and drain FSM encoding for the CELL_UNIT result path.
package cnn_accel_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int IN_W_DEF       = 4 * DATA_WIDTH_DEF;
  localparam int LANES_DEF      = 16;
  localparam int ACC_WIDTH_DEF  = IN_W_DEF + 4;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int LANE_IDX_W     = $clog2(LANES_DEF);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;
endpackage

// File: rtl/psum_saturate.sv
// Combinational clamp of a signed accumulator to the signed output word, with a clip flag.
// Optional ReLU ahead of the clamp when PSUM_RELU_EN is defined.
module psum_saturate
  import cnn_accel_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic        [OUT_WIDTH-1:0] o_word,
  output logic                        o_clip
);
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] w_val;

  always_comb begin
`ifdef PSUM_RELU_EN
    w_val = i_acc[ACC_WIDTH-1] ? '0 : i_acc;
`else
    w_val = i_acc;
`endif
    o_clip = 1'b0;
    o_word = w_val[OUT_WIDTH-1:0];
    if (w_val > MAX_V) begin
      o_word = MAX_V[OUT_WIDTH-1:0];
      o_clip = 1'b1;
    end else if (w_val < MIN_V) begin
      o_word = MIN_V[OUT_WIDTH-1:0];
      o_clip = 1'b1;
    end
  end
endmodule

// File: rtl/psum_drain_buffer.sv
// Accumulates array result lanes across passes, snapshots final sums and drains them one
// saturated word per handshake. Define PSUM_RELU_EN to zero negative sums before the clamp.
module psum_drain_buffer
  import cnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                              Clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_first,
  input  logic                              in_last,
  input  logic [LANES*4*DATA_WIDTH-1:0]     in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic [$clog2(LANES)-1:0]          out_idx,
  output logic                              out_last,
  output logic                              sat_flag
);
  localparam int IN_W  = 4 * DATA_WIDTH;
  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  drain_state_t r_state, w_state_next;

  logic signed [ACC_WIDTH-1:0] r_acc   [LANES];
  logic signed [ACC_WIDTH-1:0] r_drain [LANES];
  logic signed [ACC_WIDTH-1:0] w_sum   [LANES];

  logic                    r_drain_full;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_inc;
  logic [OUT_WIDTH-1:0]    r_out_data;
  logic                    r_out_clip;
  logic                    r_sat;
  logic                    w_accept;
  logic                    w_load_drain;
  logic                    w_out_fire;
  logic                    w_final;
  logic signed [ACC_WIDTH-1:0] w_sat_src;
  logic [OUT_WIDTH-1:0]    w_sat_word;
  logic                    w_sat_clip;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready     = ~r_drain_full;
  assign w_accept     = in_valid & ~r_drain_full;
  assign w_load_drain = w_accept & in_last;
  assign out_valid    = (r_state == DRAIN);
  assign w_out_fire   = out_valid & out_ready;
  assign out_last     = out_valid & (r_idx == LAST_IDX);
  assign w_final      = w_out_fire & out_last;
  assign w_idx_inc    = r_idx + 1'b1;
  assign out_idx      = r_idx;
  assign out_data     = r_out_data;
  assign sat_flag     = r_sat;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [IN_W-1:0] w_lane;
      assign w_lane     = in_data[gi*IN_W +: IN_W];
      assign w_sum[gi]  = (in_first ? '0 : r_acc[gi]) + ACC_WIDTH'(w_lane);

      always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
          r_acc[gi]   <= '0;
          r_drain[gi] <= '0;
        end else if (w_accept) begin
          r_acc[gi] <= w_sum[gi];
          if (in_last) r_drain[gi] <= w_sum[gi];
        end
      end
    end
  endgenerate

  // The first drained word comes straight from the beat being accepted so it is valid next cycle.
  always_comb begin
    w_sat_src = r_drain[w_idx_inc];
    if (w_load_drain) w_sat_src = w_sum[0];
  end

  psum_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .i_acc  (w_sat_src),
    .o_word (w_sat_word),
    .o_clip (w_sat_clip)
  );

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_drain_full <= 1'b0;
      r_idx        <= '0;
      r_out_data   <= '0;
      r_out_clip   <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      if (w_accept && in_first) r_sat <= 1'b0;
      else if (w_out_fire && r_out_clip) r_sat <= 1'b1;

      if (w_load_drain) begin
        r_drain_full <= 1'b1;
        r_idx        <= '0;
        r_out_data   <= w_sat_word;
        r_out_clip   <= w_sat_clip;
      end else if (w_final) begin
        r_drain_full <= 1'b0;
        r_idx        <= '0;
        r_out_data   <= '0;
        r_out_clip   <= 1'b0;
      end else if (w_out_fire) begin
        r_idx        <= w_idx_inc;
        r_out_data   <= w_sat_word;
        r_out_clip   <= w_sat_clip;
      end
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load_drain) w_state_next = DRAIN;
      DRAIN:   if (w_final) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_psum_drain_buffer.sv
// Directed plus randomized bench for psum_drain_buffer against a per-lane arithmetic model.
// Expectations follow PSUM_RELU_EN when it is defined for the build.
module tb_psum_drain_buffer;
  localparam int LANES = 16;
  localparam int IN_W  = 32;

  logic                   Clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_data;
  logic [3:0]             out_idx;
  logic                   out_last;
  logic                   sat_flag;

  psum_drain_buffer dut (
    .Clk       (Clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sat_flag  (sat_flag)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_errors = 0;
  longint      m_acc  [LANES];
  logic [15:0] m_word [LANES];
  bit          m_clip [LANES];
  bit          m_sat;
  logic [31:0] lane_v [LANES];

`ifdef PSUM_RELU_EN
  localparam logic [15:0] EXP_NEG5 = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG5 = 16'hFFFB;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keep the low 36 bits as a signed value.
  function automatic longint wrap36(input longint v);
    return (v <<< 28) >>> 28;
  endfunction

  // Returns {clip, word}.
  function automatic logic [16:0] sat_model(input longint v);
    longint x;
    x = v;
`ifdef PSUM_RELU_EN
    if (x < 0) x = 0;
`endif
    if (x > 32767)  return {1'b1, 16'h7FFF};
    if (x < -32768) return {1'b1, 16'h8000};
    return {1'b0, x[15:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_acc[i] = 0;
    m_sat = 1'b0;
  endtask

  task automatic set_lanes(input logic [31:0] v);
    for (int i = 0; i < LANES; i++) lane_v[i] = v;
  endtask

  // Starts and ends on a falling edge.
  task automatic send_beat(input bit first, input bit last);
    logic [16:0] s;
    check("in_ready_before_beat", in_ready, 1);
    for (int i = 0; i < LANES; i++) in_data[i*IN_W +: IN_W] = lane_v[i];
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    if (first) m_sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      m_acc[i] = wrap36((first ? 64'sd0 : m_acc[i]) + longint'($signed(lane_v[i])));
      if (last) begin
        s = sat_model(m_acc[i]);
        m_word[i] = s[15:0];
        m_clip[i] = s[16];
      end
    end
  endtask

  // mode 0: always ready, 1: toggle 1,0,1,0..., 2: random. stop_at >= 0 returns with that word showing.
  task automatic drain_all(input int mode, input int stop_at);
    int k;
    int cyc;
    bit fire;
    k = 0;
    cyc = 0;
    while (k < LANES) begin
      if (cyc > 400) begin
        n_checks++;
        n_errors++;
        $error("FAIL drain_timeout: observed words=%0d required=%0d", k, LANES);
        break;
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, m_word[k]);
      check("out_idx", out_idx, k);
      check("out_last", out_last, (k == LANES - 1));
      check("in_ready_drain", in_ready, 0);
      if (k == stop_at) return;
      case (mode)
        0:       fire = 1'b1;
        1:       fire = (cyc % 2 == 0);
        default: fire = 1'($urandom_range(0, 1));
      endcase
      out_ready = fire;
      @(negedge Clk);
      if (fire) begin
        if (m_clip[k]) m_sat = 1'b1;
        k++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_end", out_valid, 0);
    check("in_ready_end", in_ready, 1);
    check("out_idx_end", out_idx, 0);
    check("out_last_end", out_last, 0);
    check("sat_flag_end", sat_flag, m_sat);
  endtask

  initial begin
    int np;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat_flag", sat_flag, 0);
    rst = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < LANES; i++) lane_v[i] = 32'(i);
    send_beat(1'b1, 1'b1);
    drain_all(0, -1);
    $display("job single_beat: lanes 0..15 drained, sat_flag=%0b", sat_flag);

    set_lanes(32'd100);
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b1);
    check("three_pass_word0", out_data, 16'd300);
    drain_all(0, -1);
    $display("job three_pass: 16 words of 300");

    set_lanes(32'd0);
    lane_v[0] = 32'h7FFF_FFFF;
    lane_v[1] = 32'h8000_0000;
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b1);
    check("sat_word0", out_data, 16'h7FFF);
    drain_all(0, -1);
    check("sat_flag_set", sat_flag, 1);
    $display("job saturate: sat_flag=%0b", sat_flag);

    for (int i = 0; i < LANES; i++) lane_v[i] = 32'($urandom_range(0, 60000)) - 32'd30000;
    send_beat(1'b1, 1'b1);
    check("sat_flag_cleared", sat_flag, m_sat);
    // Offer junk while draining; it must be ignored.
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
    in_data = {LANES{32'h1234_5678}};
    drain_all(1, -1);
    set_lanes(32'd1);
    send_beat(1'b0, 1'b1);
    drain_all(2, -1);
    $display("job stall_and_continue: drained with toggled out_ready");

    for (int i = 0; i < LANES; i++) lane_v[i] = $urandom;
    send_beat(1'b1, 1'b1);
    drain_all(0, 7);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_idx", out_idx, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    check("arst_sat_flag", sat_flag, 0);
    model_reset();
    @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    set_lanes(32'd5);
    send_beat(1'b0, 1'b1);
    check("post_rst_word0", out_data, 16'd5);
    drain_all(0, -1);
    $display("job reset_mid_drain: new pass drained 5s");

    set_lanes(32'hFFFF_FFFB);
    send_beat(1'b1, 1'b1);
    check("neg5_word0", out_data, EXP_NEG5);
    drain_all(0, -1);
    $display("job neg5: word=%04h", EXP_NEG5);

    for (int j = 0; j < 8; j++) begin
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        for (int i = 0; i < LANES; i++)
          lane_v[i] = ($urandom_range(0, 3) == 0) ? $urandom
                                                  : 32'($urandom_range(0, 40000)) - 32'd20000;
        if ($urandom_range(0, 1) == 1) @(negedge Clk);
        send_beat(p == 0, p == np - 1);
      end
      drain_all(2, -1);
      $display("job random%0d: %0d passes drained, sat_flag=%0b", j, np, sat_flag);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
